layer_norm_row_sequencer: RTL and testbench
===========================================

# layer_norm_row_sequencer

Streaming, parametrised row sequencer for matrix LayerNorm. It accepts matrix rows over a valid/ready input stream and dispatches each row to an external single-row LayerNorm engine through a start/done port pair. It returns normalised rows, in order, over a valid/ready output stream with a last-row marker. It replaces flattened whole-matrix buses with per-row transfers, supports a runtime row count, prefetches the next row while the engine is busy, and tolerates output backpressure through a 2-entry result FIFO.

## Interface
- COLS, 64, elements per row (engine vector length)
- X_WIDTH, 16, bits per input element
- Y_WIDTH, 16, bits per output element
- MAX_ROWS, 64, largest supported row count
- ROW_CNT_WIDTH, $clog2(MAX_ROWS+1), width of row counters and num_rows

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin matrix; honoured only in IDLE
- num_rows  in  ROW_CNT_WIDTH  rows in matrix; sampled when start is honoured; values >MAX_ROWS saturate to MAX_ROWS
- in_valid / in_ready  in / out  1 / 1  input row handshake
- in_row  in  COLS*X_WIDTH  input row, element 0 in the LSBs
- eng_start  out  1  registered one-cycle pulse to engine
- eng_x_row  out  COLS*X_WIDTH  registered; held stable from eng_start until eng_done
- eng_done  in  1  engine one-cycle result strobe
- eng_y_row  in  COLS*Y_WIDTH  engine result, valid with eng_done
- out_valid / out_ready  out / in  1 / 1  output row handshake
- out_row  out  COLS*Y_WIDTH  FIFO head
- out_last  out  1  high with out_valid on the final row
- busy  out  1  high in RUN
- matrix_done  out  1  one-cycle pulse in DONE
- err_zero_rows  out  1  one-cycle pulse: start with num_rows==0
- err_spurious_done  out  1  one-cycle pulse: eng_done while no row in flight
- rows_out_count  out  ROW_CNT_WIDTH  rows emitted in current matrix

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - start with num_rows==0: pulse err_zero_rows; stay in IDLE.
  - start with num_rows!=0: latch N; clear all counters; go to RUN.
- RUN:
  - Input buffer (1 entry): in_ready = !in_buf_valid && rows_accepted<N. A handshake loads in_buf and increments rows_accepted.
  - Issue, when in_buf_valid && !in_flight && fifo_count<2:
    - Register eng_start=1 and eng_x_row=in_buf.
    - Clear in_buf_valid; set in_flight.
  - eng_done with in_flight:
    - Push eng_y_row into the FIFO; clear in_flight.
    - The issue rule guarantees the FIFO never overflows.
  - eng_done without in_flight: pulse err_spurious_done; data discarded.
  - Output:
    - out_valid = fifo_count!=0.
    - out_last = out_valid && rows_out_count==N-1.
    - A handshake pops the FIFO and increments rows_out_count.
    - A simultaneous push and pop leaves the count unchanged and keeps order.
  - The handshake of the last row moves the FSM to DONE.
- DONE: matrix_done=1 for one cycle, then IDLE.
- start outside IDLE is ignored.
- Reset, asynchronous and possibly mid-matrix:
  - State returns to IDLE.
  - All counters, in_buf, FIFO, eng_x_row and out_row are zeroed.
  - All flags and pulses are 0 and in_ready=0.
  - A later eng_done from the aborted row is flagged as spurious.

## Timing
- start honoured at edge E: in_ready may be 1 from cycle E+1.
- Input handshake at edge E0, engine idle, FIFO not full: eng_start is high in the cycle after edge E0+1, so 1 cycle of issue latency.
- in_ready returns high one cycle after issue, which allows prefetch of row k+1 during the engine run of row k.
- eng_done sampled at edge Ed: out_valid=1 from cycle Ed+1.
- Last output handshake at edge El: matrix_done high during cycle El+1; busy=0 from El+1; IDLE from El+2.
- Throughput is one row per engine latency plus 1 cycle, given no backpressure.

## Test plan
- Reset mid-RUN, after 3 of N=8 rows out: all outputs 0 next cycle. Stale eng_done -> err_spurious_done=1. A new start with N=2 completes normally.
- N=4, always-ready sink, engine model latency 10, row r elements = r: 4 output rows in order, out_last only on row 3, matrix_done one cycle after the row-3 handshake, eng_start spacing 11 cycles.
- N=3, out_ready=0 for 60 cycles: exactly 2 rows issued and FIFO full, third row held in in_buf, in_ready=0, no issue. After release, all 3 rows out in order.
- start with num_rows=0: err_zero_rows pulse, busy stays 0, in_ready stays 0.
- start asserted during RUN with a different num_rows: ignored; the original N rows are emitted.
- num_rows=MAX_ROWS=64 with random in_valid/out_ready: 64 rows in order, rows_out_count reaches 63 at out_last, eng_x_row stable during every in-flight window.

Source files
------------

// File: rtl/layer_norm_row_sequencer.sv
// Row sequencer for matrix LayerNorm: streams rows into a single-row engine,
// prefetching the next row while the engine runs and buffering results in a 2-entry FIFO.
module layer_norm_row_sequencer #(
    parameter int COLS          = 64,
    parameter int X_WIDTH       = 16,
    parameter int Y_WIDTH       = 16,
    parameter int MAX_ROWS      = 64,
    parameter int ROW_CNT_WIDTH = $clog2(MAX_ROWS + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [ROW_CNT_WIDTH-1:0] num_rows,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [COLS*X_WIDTH-1:0]  in_row,
    output logic                     eng_start,
    output logic [COLS*X_WIDTH-1:0]  eng_x_row,
    input  logic                     eng_done,
    input  logic [COLS*Y_WIDTH-1:0]  eng_y_row,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [COLS*Y_WIDTH-1:0]  out_row,
    output logic                     out_last,
    output logic                     busy,
    output logic                     matrix_done,
    output logic                     err_zero_rows,
    output logic                     err_spurious_done,
    output logic [ROW_CNT_WIDTH-1:0] rows_out_count
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [ROW_CNT_WIDTH-1:0] MAX_ROWS_C = ROW_CNT_WIDTH'(MAX_ROWS);
    localparam logic [ROW_CNT_WIDTH-1:0] ONE_C      = ROW_CNT_WIDTH'(1);

    state_t                   state;
    logic [ROW_CNT_WIDTH-1:0] n_rows;
    logic [ROW_CNT_WIDTH-1:0] rows_accepted;
    logic [COLS*X_WIDTH-1:0]  in_buf;
    logic                     in_buf_valid;
    logic                     in_flight;
    logic [COLS*Y_WIDTH-1:0]  fifo_mem [2];
    logic                     fifo_wr_ptr;
    logic                     fifo_rd_ptr;
    logic [1:0]               fifo_count;
    logic                     in_fire;
    logic                     out_fire;
    logic                     issue;
    logic                     push;

    always_comb begin
        in_ready  = (state == RUN) && !in_buf_valid && (rows_accepted < n_rows);
        out_valid = (fifo_count != 2'd0);
        out_last  = out_valid && (rows_out_count == n_rows - ONE_C);
        out_row   = fifo_mem[fifo_rd_ptr];
        busy      = (state == RUN);
        in_fire   = in_valid && in_ready;
        out_fire  = out_valid && out_ready;
        // Holding issue while the FIFO is full is what keeps a result from ever overflowing it.
        issue     = (state == RUN) && in_buf_valid && !in_flight && (fifo_count < 2'd2);
        push      = eng_done && in_flight;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= IDLE;
            n_rows            <= '0;
            rows_accepted     <= '0;
            rows_out_count    <= '0;
            in_buf            <= '0;
            in_buf_valid      <= 1'b0;
            in_flight         <= 1'b0;
            eng_start         <= 1'b0;
            eng_x_row         <= '0;
            fifo_mem[0]       <= '0;
            fifo_mem[1]       <= '0;
            fifo_wr_ptr       <= 1'b0;
            fifo_rd_ptr       <= 1'b0;
            fifo_count        <= 2'd0;
            matrix_done       <= 1'b0;
            err_zero_rows     <= 1'b0;
            err_spurious_done <= 1'b0;
        end else begin
            eng_start         <= 1'b0;
            matrix_done       <= 1'b0;
            err_zero_rows     <= 1'b0;
            err_spurious_done <= eng_done && !in_flight;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (num_rows == '0) begin
                            err_zero_rows <= 1'b1;
                        end else begin
                            n_rows         <= (num_rows > MAX_ROWS_C) ? MAX_ROWS_C : num_rows;
                            rows_accepted  <= '0;
                            rows_out_count <= '0;
                            in_buf_valid   <= 1'b0;
                            in_flight      <= 1'b0;
                            fifo_wr_ptr    <= 1'b0;
                            fifo_rd_ptr    <= 1'b0;
                            fifo_count     <= 2'd0;
                            state          <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (in_fire) begin
                        in_buf        <= in_row;
                        in_buf_valid  <= 1'b1;
                        rows_accepted <= rows_accepted + ONE_C;
                    end
                    if (issue) begin
                        eng_start    <= 1'b1;
                        eng_x_row    <= in_buf;
                        in_buf_valid <= 1'b0;
                        in_flight    <= 1'b1;
                    end
                    if (push) begin
                        fifo_mem[fifo_wr_ptr] <= eng_y_row;
                        fifo_wr_ptr           <= ~fifo_wr_ptr;
                        in_flight             <= 1'b0;
                    end
                    if (out_fire) begin
                        fifo_rd_ptr    <= ~fifo_rd_ptr;
                        rows_out_count <= rows_out_count + ONE_C;
                        if (out_last) begin
                            state       <= DONE;
                            matrix_done <= 1'b1;
                        end
                    end
                    case ({push, out_fire})
                        2'b10:   fifo_count <= fifo_count + 2'd1;
                        2'b01:   fifo_count <= fifo_count - 2'd1;
                        default: fifo_count <= fifo_count;
                    endcase
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_layer_norm_row_sequencer.sv
// Bench for layer_norm_row_sequencer: latency-10 engine model, row scoreboard
// and directed matrix scenarios including mid-matrix reset and backpressure.
module tb_layer_norm_row_sequencer;
    localparam int COLS     = 4;
    localparam int X_WIDTH  = 16;
    localparam int Y_WIDTH  = 16;
    localparam int MAX_ROWS = 64;
    localparam int RCW      = $clog2(MAX_ROWS + 1);
    localparam int ENG_LAT  = 10;

    logic                    clk = 1'b0;
    logic                    rst = 1'b0;
    logic                    start = 1'b0;
    logic [RCW-1:0]          num_rows = '0;
    logic                    in_valid = 1'b0;
    logic                    in_ready;
    logic [COLS*X_WIDTH-1:0] in_row = '0;
    logic                    eng_start;
    logic [COLS*X_WIDTH-1:0] eng_x_row;
    logic                    eng_done = 1'b0;
    logic [COLS*Y_WIDTH-1:0] eng_y_row = '0;
    logic                    out_valid;
    logic                    out_ready = 1'b0;
    logic [COLS*Y_WIDTH-1:0] out_row;
    logic                    out_last;
    logic                    busy;
    logic                    matrix_done;
    logic                    err_zero_rows;
    logic                    err_spurious_done;
    logic [RCW-1:0]          rows_out_count;

    typedef struct {
        logic [63:0] y;
        logic        last;
    } exp_t;

    exp_t        exp_q[$];
    int          test_count = 0;
    int          fail_count = 0;
    int          sink_mode = 0;
    int          cur_n = 0;
    int          in_idx = 0;
    int          out_idx = 0;
    int          issue_count = 0;
    int          cyc = 0;
    int          last_start = 0;
    int          gap_min = 1000;
    int          gap_max = 0;
    logic        done_next = 1'b0;
    logic        win = 1'b0;
    logic [63:0] win_x = '0;

    layer_norm_row_sequencer #(
        .COLS(COLS), .X_WIDTH(X_WIDTH), .Y_WIDTH(Y_WIDTH), .MAX_ROWS(MAX_ROWS), .ROW_CNT_WIDTH(RCW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .num_rows(num_rows),
        .in_valid(in_valid), .in_ready(in_ready), .in_row(in_row),
        .eng_start(eng_start), .eng_x_row(eng_x_row), .eng_done(eng_done), .eng_y_row(eng_y_row),
        .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row), .out_last(out_last),
        .busy(busy), .matrix_done(matrix_done), .err_zero_rows(err_zero_rows),
        .err_spurious_done(err_spurious_done), .rows_out_count(rows_out_count)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] engModel(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int c = 0; c < COLS; c++) y[c*16 +: 16] = x[c*16 +: 16] * 16'd3 + 16'h0101;
        return y;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        test_count++;
        assert (observed === expected) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_in_ready"}, 64'(in_ready), 64'd0);
        checkOutput({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        checkOutput({tag, "_out_last"}, 64'(out_last), 64'd0);
        checkOutput({tag, "_out_row"}, 64'(out_row), 64'd0);
        checkOutput({tag, "_eng_start"}, 64'(eng_start), 64'd0);
        checkOutput({tag, "_eng_x_row"}, 64'(eng_x_row), 64'd0);
        checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
        checkOutput({tag, "_matrix_done"}, 64'(matrix_done), 64'd0);
        checkOutput({tag, "_err_zero"}, 64'(err_zero_rows), 64'd0);
        checkOutput({tag, "_err_spur"}, 64'(err_spurious_done), 64'd0);
        checkOutput({tag, "_rows_out"}, 64'(rows_out_count), 64'd0);
    endtask

    task automatic startMatrix(input int n);
        @(posedge clk); #1;
        start    = 1'b1;
        num_rows = RCW'(n);
        @(posedge clk); #1;
        start    = 1'b0;
    endtask

    // Sends n rows whose elements all equal base+r; gives up quietly if reset hits mid-matrix.
    task automatic applyStimulus(input int n, input bit rand_valid, input logic [15:0] base);
        bit          aborted;
        bit          accepted;
        logic [15:0] e;
        aborted = 1'b0;
        for (int r = 0; r < n && !aborted; r++) begin
            if (rand_valid) begin
                while ($urandom_range(0, 2) == 0) begin
                    @(posedge clk); #1;
                end
            end
            e        = base + 16'(r);
            in_row   = {COLS{e}};
            in_valid = 1'b1;
            accepted = 1'b0;
            for (int t = 0; t < 400 && !accepted && !aborted; t++) begin
                @(negedge clk);
                if (rst) aborted = 1'b1;
                accepted = in_ready && !rst;
                @(posedge clk); #1;
            end
            in_valid = 1'b0;
            if (!aborted) checkOutput("in_accept", 64'(accepted), 64'd1);
        end
    endtask

    task automatic waitDone(input string tag, input int budget);
        bit seen;
        seen = 1'b0;
        for (int t = 0; t < budget && !seen; t++) begin
            @(negedge clk);
            seen = matrix_done;
        end
        checkOutput(tag, 64'(matrix_done), 64'd1);
        @(negedge clk);
        checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
        checkOutput({tag, "_done_pulse"}, 64'(matrix_done), 64'd0);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            eng_done = 1'b0;
            if (eng_start) begin
                win_hold_x: begin
                    logic [63:0] x;
                    x = eng_x_row;
                    repeat (ENG_LAT - 1) @(negedge clk);
                    eng_y_row = engModel(x);
                    eng_done  = 1'b1;
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            case (sink_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'b0;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Scoreboard, done-pulse timing, issue spacing and eng_x_row hold checks, sampled mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                exp_q.delete();
                win       = 1'b0;
                done_next = 1'b0;
            end else begin
                checkOutput("matrix_done", 64'(matrix_done), 64'(done_next));
                done_next = 1'b0;
                if (start && !busy && !matrix_done && num_rows != '0) begin
                    cur_n       = (int'(num_rows) > MAX_ROWS) ? MAX_ROWS : int'(num_rows);
                    in_idx      = 0;
                    out_idx     = 0;
                    issue_count = 0;
                    gap_min     = 1000;
                    gap_max     = 0;
                end
                if (in_valid && in_ready) begin
                    e.y    = engModel(in_row);
                    e.last = (in_idx == cur_n - 1);
                    exp_q.push_back(e);
                    in_idx++;
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        checkOutput("out_unexpected", 64'(out_valid), 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("out_row", 64'(out_row), e.y);
                        checkOutput("out_last", 64'(out_last), 64'(e.last));
                        checkOutput("out_count", 64'(rows_out_count), 64'(out_idx));
                        out_idx++;
                        done_next = e.last;
                    end
                end else if (out_valid) begin
                    checkOutput("out_last_idle", 64'(out_last), 64'(out_idx == cur_n - 1));
                end
                if (win) begin
                    checkOutput("x_stable", 64'(eng_x_row), win_x);
                    if (eng_done) win = 1'b0;
                end
                if (eng_start) begin
                    win   = 1'b1;
                    win_x = 64'(eng_x_row);
                    if (issue_count > 0) begin
                        if (cyc - last_start < gap_min) gap_min = cyc - last_start;
                        if (cyc - last_start > gap_max) gap_max = cyc - last_start;
                    end
                    last_start = cyc;
                    issue_count++;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bit seen;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        checkResetState("por");
        @(posedge clk); #1 rst = 1'b0;

        // Mid-matrix reset after three rows have left, then the stale engine result must be flagged.
        startMatrix(8);
        fork
            applyStimulus(8, 1'b0, 16'h0100);
            begin
                seen = 1'b0;
                for (int t = 0; t < 500 && !seen; t++) begin
                    @(negedge clk);
                    seen = (rows_out_count == RCW'(3));
                end
                checkOutput("rst_wait3", 64'(rows_out_count), 64'd3);
                repeat (3) @(posedge clk);
                #1 rst = 1'b1;
                @(negedge clk);
                checkResetState("mid_rst");
                repeat (2) @(posedge clk);
                #1 rst = 1'b0;
            end
        join
        seen = 1'b0;
        for (int t = 0; t < 30 && !seen; t++) begin
            @(negedge clk);
            seen = eng_done;
        end
        checkOutput("stale_done_seen", 64'(eng_done), 64'd1);
        @(negedge clk);
        checkOutput("spurious_flag", 64'(err_spurious_done), 64'd1);
        @(negedge clk);
        checkOutput("spurious_pulse", 64'(err_spurious_done), 64'd0);

        startMatrix(2);
        applyStimulus(2, 1'b0, 16'h0200);
        waitDone("n2_done", 400);
        checkOutput("n2_count", 64'(rows_out_count), 64'd2);

        // Free-flowing matrix: issues must be exactly engine latency plus one apart.
        startMatrix(4);
        applyStimulus(4, 1'b0, 16'h0000);
        waitDone("n4_done", 400);
        checkOutput("n4_issues", 64'(issue_count), 64'd4);
        checkOutput("n4_gap_min", 64'(gap_min), 64'd11);
        checkOutput("n4_gap_max", 64'(gap_max), 64'd11);

        sink_mode = 1;
        startMatrix(3);
        applyStimulus(3, 1'b0, 16'h0300);
        repeat (50) @(posedge clk);
        @(negedge clk);
        checkOutput("bp_issues", 64'(issue_count), 64'd2);
        checkOutput("bp_in_ready", 64'(in_ready), 64'd0);
        checkOutput("bp_out_valid", 64'(out_valid), 64'd1);
        checkOutput("bp_eng_start", 64'(eng_start), 64'd0);
        checkOutput("bp_busy", 64'(busy), 64'd1);
        sink_mode = 0;
        waitDone("bp_done", 400);
        checkOutput("bp_count", 64'(rows_out_count), 64'd3);

        startMatrix(0);
        @(negedge clk);
        checkOutput("zero_err", 64'(err_zero_rows), 64'd1);
        checkOutput("zero_busy", 64'(busy), 64'd0);
        checkOutput("zero_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        checkOutput("zero_err_pulse", 64'(err_zero_rows), 64'd0);
        checkOutput("zero_busy2", 64'(busy), 64'd0);

        startMatrix(3);
        @(posedge clk); #1;
        start    = 1'b1;
        num_rows = RCW'(5);
        @(posedge clk); #1;
        start    = 1'b0;
        applyStimulus(3, 1'b0, 16'h0500);
        waitDone("ign_done", 400);
        checkOutput("ign_count", 64'(rows_out_count), 64'd3);
        checkOutput("ign_in_ready", 64'(in_ready), 64'd0);

        sink_mode = 2;
        startMatrix(MAX_ROWS);
        applyStimulus(MAX_ROWS, 1'b1, 16'h1000);
        waitDone("max_done", 5000);
        sink_mode = 0;
        checkOutput("max_count", 64'(rows_out_count), 64'd64);
        checkOutput("max_issues", 64'(issue_count), 64'd64);

        startMatrix(100);
        applyStimulus(MAX_ROWS, 1'b0, 16'h2000);
        waitDone("sat_done", 3000);
        checkOutput("sat_count", 64'(rows_out_count), 64'd64);
        checkOutput("sat_in_ready", 64'(in_ready), 64'd0);

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end
endmodule
